tennis_set_fsm: RTL and testbench

- Successor to the single-game scorer; tracks points, games and sets for one match. Games-per-set and tie-break length are parameters.
- Adds tie-break play, serve tracking and an illegal-input flag. There is no dead cycle after a game win; a point arriving in the win-pulse cycle is scored.
- Sits between the debounced point-button front end and the scoreboard display driver.

---
 rtl/tennis_set_fsm.sv | 274 +++++++++++++++++++++++++++
 tb/tb_tennis_set_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tennis_set_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tennis_set_fsm
// Brief    : Point/game/set scorer with deuce, serve tracking and error flag.
//            Define TIEBREAK_EN for tie-break sets; otherwise advantage sets.
// Revision : 1.0 - initial release
// ============================================================================
module tennis_set_fsm #(
    parameter  int GAMES_TO_WIN = 6,
    parameter  int TB_POINTS    = 7,
    parameter  int SET_W        = 3,
    localparam int GAME_W       = $clog2(GAMES_TO_WIN + 2),
    localparam int TB_W         = $clog2(TB_POINTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p1_point,
    input  logic              p2_point,
    output logic [2:0]        game_state,
    output logic [1:0]        p1_pts,
    output logic [1:0]        p2_pts,
    output logic [TB_W-1:0]   p1_tb,
    output logic [TB_W-1:0]   p2_tb,
    output logic [GAME_W-1:0] p1_games,
    output logic [GAME_W-1:0] p2_games,
    output logic [SET_W-1:0]  p1_sets,
    output logic [SET_W-1:0]  p2_sets,
    output logic              server,
    output logic              p1_game_win,
    output logic              p2_game_win,
    output logic              p1_set_win,
    output logic              p2_set_win,
    output logic              point_err
);

    typedef enum logic [2:0] {
        S_PLAY   = 3'd0,
        S_DEUCE  = 3'd1,
        S_ADV_P1 = 3'd2,
        S_ADV_P2 = 3'd3,
        S_TB     = 3'd4
    } state_t;

    localparam logic [GAME_W:0]   c_g      = (GAME_W+1)'(GAMES_TO_WIN);
    localparam logic [GAME_W:0]   c_g_m2   = (GAME_W+1)'(GAMES_TO_WIN - 2);
    localparam logic [GAME_W:0]   c_g_p1   = (GAME_W+1)'(GAMES_TO_WIN + 1);
    localparam logic [GAME_W-1:0] c_g_full = GAME_W'(GAMES_TO_WIN);
    localparam logic [TB_W:0]     c_tb     = (TB_W+1)'(TB_POINTS);
    localparam logic [TB_W-1:0]   c_tb_m1  = TB_W'(TB_POINTS - 1);

    state_t            r_state, w_state;
    logic [1:0]        r_p1_pts, r_p2_pts, w_p1_pts, w_p2_pts;
    logic [TB_W-1:0]   r_p1_tb, r_p2_tb, w_p1_tb, w_p2_tb;
    logic [GAME_W-1:0] r_p1_games, r_p2_games, w_p1_games, w_p2_games;
    logic [SET_W-1:0]  r_p1_sets, r_p2_sets, w_p1_sets, w_p2_sets;
    logic              r_server, w_server, r_tb_first, w_tb_first;
    logic              r_p1_gw, r_p2_gw, r_p1_sw, r_p2_sw, r_err;
    logic              w_p1_gw, w_p2_gw, w_p1_sw, w_p2_sw, w_err;
    logic              w_game_won, w_tb_pt;

    // Decoded point inputs and winner/loser views of the current score
    logic              w_pt1, w_pt2, w_one, w_both;
    logic [1:0]        w_win_pts, w_los_pts;
    logic [GAME_W:0]   w_win_games, w_los_games;
    logic [TB_W:0]     w_s_tb, w_o_tb;
    logic              w_tb_par, w_set_won, w_games_back, w_tb_start;

    assign w_pt1       = p1_point & ~p2_point;
    assign w_pt2       = p2_point & ~p1_point;
    assign w_one       = w_pt1 | w_pt2;
    assign w_both      = p1_point & p2_point;
    assign w_win_pts   = w_pt2 ? r_p2_pts : r_p1_pts;
    assign w_los_pts   = w_pt2 ? r_p1_pts : r_p2_pts;
    assign w_win_games = {1'b0, (w_pt2 ? r_p2_games : r_p1_games)} + (GAME_W+1)'(1);
    assign w_los_games = {1'b0, (w_pt2 ? r_p1_games : r_p2_games)};
    assign w_s_tb      = {1'b0, (w_pt2 ? r_p2_tb : r_p1_tb)} + (TB_W+1)'(1);
    assign w_o_tb      = {1'b0, (w_pt2 ? r_p1_tb : r_p2_tb)};
    // Parity of the tie-break total before this point; even means the new total is odd
    assign w_tb_par    = r_p1_tb[0] ^ r_p2_tb[0];

`ifdef TIEBREAK_EN
    assign w_tb_start   = (r_p1_games == c_g_full) && (r_p2_games == c_g_full);
    assign w_set_won    = ((w_win_games == c_g) && (w_los_games <= c_g_m2)) ||
                          (w_win_games == c_g_p1);
    assign w_games_back = 1'b0;
    assign p1_tb        = r_p1_tb;
    assign p2_tb        = r_p2_tb;
`else
    localparam logic [GAME_W:0] c_g_m1 = (GAME_W+1)'(GAMES_TO_WIN - 1);
    localparam logic [GAME_W:0] c_g_p2 = (GAME_W+1)'(GAMES_TO_WIN + 2);
    assign w_tb_start   = 1'b0;
    assign w_set_won    = ((w_win_games == c_g) && (w_los_games <= c_g_m2)) ||
                          ((w_win_games == c_g_p1) && (w_los_games <= c_g_m1)) ||
                          (w_win_games == c_g_p2);
    assign w_games_back = (w_win_games == c_g_p1) && (w_los_games == c_g_p1);
    assign p1_tb        = '0;
    assign p2_tb        = '0;
`endif

    always_comb begin
        w_state    = r_state;
        w_p1_pts   = r_p1_pts;
        w_p2_pts   = r_p2_pts;
        w_p1_tb    = r_p1_tb;
        w_p2_tb    = r_p2_tb;
        w_p1_games = r_p1_games;
        w_p2_games = r_p2_games;
        w_p1_sets  = r_p1_sets;
        w_p2_sets  = r_p2_sets;
        w_server   = r_server;
        w_tb_first = r_tb_first;
        w_p1_gw    = 1'b0;
        w_p2_gw    = 1'b0;
        w_p1_sw    = 1'b0;
        w_p2_sw    = 1'b0;
        w_err      = 1'b0;
        w_game_won = 1'b0;
        w_tb_pt    = 1'b0;

        case (r_state)
            S_PLAY: begin
                w_err = w_both;
                if (w_tb_start) begin
                    // Entry edge already scores as the first tie-break point
                    w_state    = S_TB;
                    w_tb_first = r_server;
                    w_tb_pt    = w_one;
                end else if (w_one) begin
                    if (w_win_pts == 2'd3) begin
                        w_game_won = 1'b1;
                    end else if (w_win_pts == 2'd2 && w_los_pts == 2'd3) begin
                        w_state  = S_DEUCE;
                        w_p1_pts = 2'd3;
                        w_p2_pts = 2'd3;
                    end else if (w_pt2) begin
                        w_p2_pts = r_p2_pts + 2'd1;
                    end else begin
                        w_p1_pts = r_p1_pts + 2'd1;
                    end
                end
            end
            S_DEUCE: begin
                w_err = w_both;
                if (w_pt1)      w_state = S_ADV_P1;
                else if (w_pt2) w_state = S_ADV_P2;
            end
            S_ADV_P1: begin
                w_err = w_both;
                if (w_pt1)      w_game_won = 1'b1;
                else if (w_pt2) w_state    = S_DEUCE;
            end
            S_ADV_P2: begin
                w_err = w_both;
                if (w_pt2)      w_game_won = 1'b1;
                else if (w_pt1) w_state    = S_DEUCE;
            end
`ifdef TIEBREAK_EN
            S_TB: begin
                w_err   = w_both;
                w_tb_pt = w_one;
            end
`endif
            default: begin
                w_state  = S_PLAY;
                w_p1_pts = 2'd0;
                w_p2_pts = 2'd0;
                w_p1_tb  = '0;
                w_p2_tb  = '0;
            end
        endcase

        if (w_game_won) begin
            w_state  = S_PLAY;
            w_p1_pts = 2'd0;
            w_p2_pts = 2'd0;
            w_server = ~r_server;
            w_p1_gw  = w_pt1;
            w_p2_gw  = w_pt2;
            if (w_set_won) begin
                w_p1_games = '0;
                w_p2_games = '0;
                w_p1_sw    = w_pt1;
                w_p2_sw    = w_pt2;
            end else if (w_games_back) begin
                w_p1_games = c_g_full;
                w_p2_games = c_g_full;
            end else if (w_pt2) begin
                w_p2_games = w_win_games[GAME_W-1:0];
            end else begin
                w_p1_games = w_win_games[GAME_W-1:0];
            end
        end

        if (w_tb_pt) begin
            if (!w_tb_par) w_server = ~r_server;
            if (w_s_tb >= c_tb && w_s_tb >= w_o_tb + (TB_W+1)'(2)) begin
                w_state    = S_PLAY;
                w_p1_tb    = '0;
                w_p2_tb    = '0;
                w_p1_games = '0;
                w_p2_games = '0;
                w_server   = ~w_tb_first;
                w_p1_gw    = w_pt1;
                w_p2_gw    = w_pt2;
                w_p1_sw    = w_pt1;
                w_p2_sw    = w_pt2;
            end else if (w_s_tb == c_tb && w_o_tb == c_tb) begin
                w_p1_tb = c_tb_m1;
                w_p2_tb = c_tb_m1;
            end else if (w_pt2) begin
                w_p2_tb = w_s_tb[TB_W-1:0];
            end else begin
                w_p1_tb = w_s_tb[TB_W-1:0];
            end
        end

        if (w_p1_sw && r_p1_sets != '1) w_p1_sets = r_p1_sets + SET_W'(1);
        if (w_p2_sw && r_p2_sets != '1) w_p2_sets = r_p2_sets + SET_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_PLAY;
            r_p1_pts   <= 2'd0;
            r_p2_pts   <= 2'd0;
            r_p1_tb    <= '0;
            r_p2_tb    <= '0;
            r_p1_games <= '0;
            r_p2_games <= '0;
            r_p1_sets  <= '0;
            r_p2_sets  <= '0;
            r_server   <= 1'b0;
            r_tb_first <= 1'b0;
            r_p1_gw    <= 1'b0;
            r_p2_gw    <= 1'b0;
            r_p1_sw    <= 1'b0;
            r_p2_sw    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_p1_pts   <= w_p1_pts;
            r_p2_pts   <= w_p2_pts;
            r_p1_tb    <= w_p1_tb;
            r_p2_tb    <= w_p2_tb;
            r_p1_games <= w_p1_games;
            r_p2_games <= w_p2_games;
            r_p1_sets  <= w_p1_sets;
            r_p2_sets  <= w_p2_sets;
            r_server   <= w_server;
            r_tb_first <= w_tb_first;
            r_p1_gw    <= w_p1_gw;
            r_p2_gw    <= w_p2_gw;
            r_p1_sw    <= w_p1_sw;
            r_p2_sw    <= w_p2_sw;
            r_err      <= w_err;
        end
    end

    assign game_state  = r_state;
    assign p1_pts      = r_p1_pts;
    assign p2_pts      = r_p2_pts;
    assign p1_games    = r_p1_games;
    assign p2_games    = r_p2_games;
    assign p1_sets     = r_p1_sets;
    assign p2_sets     = r_p2_sets;
    assign server      = r_server;
    assign p1_game_win = r_p1_gw;
    assign p2_game_win = r_p2_gw;
    assign p1_set_win  = r_p1_sw;
    assign p2_set_win  = r_p2_sw;
    assign point_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tennis_set_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_tennis_set_fsm
// Brief    : Directed bench for tennis_set_fsm (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tennis_set_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       p1_point;
    logic       p2_point;
    logic [2:0] game_state;
    logic [1:0] p1_pts, p2_pts;
    logic [2:0] p1_tb, p2_tb;
    logic [2:0] p1_games, p2_games;
    logic [2:0] p1_sets, p2_sets;
    logic       server;
    logic       p1_game_win, p2_game_win, p1_set_win, p2_set_win, point_err;

    tennis_set_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .p1_point    (p1_point),
        .p2_point    (p2_point),
        .game_state  (game_state),
        .p1_pts      (p1_pts),
        .p2_pts      (p2_pts),
        .p1_tb       (p1_tb),
        .p2_tb       (p2_tb),
        .p1_games    (p1_games),
        .p2_games    (p2_games),
        .p1_sets     (p1_sets),
        .p2_sets     (p2_sets),
        .server      (server),
        .p1_game_win (p1_game_win),
        .p2_game_win (p2_game_win),
        .p1_set_win  (p1_set_win),
        .p2_set_win  (p2_set_win),
        .point_err   (point_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        p1;
        logic        p2;
        logic [30:0] e;
    } vec_t;

    vec_t tbl[$];

    // Observation word: {state, pts, tb, games, sets, server, gw1, gw2, sw1, sw2, err}
    function automatic logic [30:0] ex(input logic [2:0] st, input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] t1, input logic [2:0] t2,
                                       input logic [2:0] ga, input logic [2:0] gb,
                                       input logic [2:0] s1, input logic [2:0] s2,
                                       input logic srv, input logic [4:0] pul);
        return {st, a, b, t1, t2, ga, gb, s1, s2, srv, pul};
    endfunction

    function automatic logic [30:0] obs();
        return {game_state, p1_pts, p2_pts, p1_tb, p2_tb, p1_games, p2_games,
                p1_sets, p2_sets, server, p1_game_win, p2_game_win, p1_set_win,
                p2_set_win, point_err};
    endfunction

    task automatic check(input string name, input logic [30:0] e);
        logic [30:0] act;
        act = obs();
        n_checks++;
        if (act !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, e);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic e);
        n_checks++;
        if (act !== e) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, e);
        end
    endtask

    task automatic add(input logic a, input logic b, input logic [2:0] st,
                       input logic [1:0] pa, input logic [1:0] pb,
                       input logic [2:0] ga, input logic [2:0] gb,
                       input logic srv, input logic [4:0] pul);
        vec_t v;
        v.p1 = a;
        v.p2 = b;
        v.e  = ex(st, pa, pb, 3'd0, 3'd0, ga, gb, 3'd0, 3'd0, srv, pul);
        tbl.push_back(v);
    endtask

    task automatic apply(input logic a, input logic b);
        @(negedge clk);
        p1_point = a;
        p2_point = b;
        @(posedge clk);
        #1;
    endtask

    task automatic game(input logic who);
        repeat (4) apply(~who, who);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        p1_point = 1'b0;
        p2_point = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [14:0] srv_exp;
        srv_exp  = 15'b011001100110011;
        rst      = 1'b1;
        p1_point = 1'b0;
        p2_point = 1'b0;

        // Love game, deuce ladder, point in pulse cycle, simultaneous inputs
        add(1'b1, 1'b0, 3'd0, 2'd1, 2'd0, 3'd0, 3'd0, 1'b0, 5'b00000);
        add(1'b1, 1'b0, 3'd0, 2'd2, 2'd0, 3'd0, 3'd0, 1'b0, 5'b00000);
        add(1'b1, 1'b0, 3'd0, 2'd3, 2'd0, 3'd0, 3'd0, 1'b0, 5'b00000);
        add(1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 3'd1, 3'd0, 1'b1, 5'b10000);
        add(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b0, 1'b1, 3'd0, 2'd0, 2'd1, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b0, 1'b1, 3'd0, 2'd0, 2'd2, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b1, 1'b0, 3'd0, 2'd1, 2'd2, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b1, 1'b0, 3'd0, 2'd2, 2'd2, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b0, 1'b1, 3'd0, 2'd2, 2'd3, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b1, 1'b0, 3'd1, 2'd3, 2'd3, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b1, 1'b0, 3'd2, 2'd3, 2'd3, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b0, 1'b1, 3'd1, 2'd3, 2'd3, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b0, 1'b1, 3'd3, 2'd3, 2'd3, 3'd1, 3'd0, 1'b1, 5'b00000);
        add(1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 3'd1, 3'd1, 1'b0, 5'b01000);
        add(1'b1, 1'b0, 3'd0, 2'd1, 2'd0, 3'd1, 3'd1, 1'b0, 5'b00000);
        add(1'b1, 1'b0, 3'd0, 2'd2, 2'd0, 3'd1, 3'd1, 1'b0, 5'b00000);
        add(1'b0, 1'b1, 3'd0, 2'd2, 2'd1, 3'd1, 3'd1, 1'b0, 5'b00000);
        add(1'b1, 1'b1, 3'd0, 2'd2, 2'd1, 3'd1, 3'd1, 1'b0, 5'b00001);
        add(1'b0, 1'b0, 3'd0, 2'd2, 2'd1, 3'd1, 3'd1, 1'b0, 5'b00000);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", 31'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].p1, tbl[i].p2);
            check($sformatf("vec%0d", i), tbl[i].e);
        end

        // Set taken 6-4 by player 2
        do_reset();
        for (int g = 0; g < 8; g++) game(g[0]);
        game(1'b1);
        check("set64_pre", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd4, 3'd5, 3'd0, 3'd0, 1'b1, 5'b01000));
        game(1'b1);
        check("set64_win", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 1'b0, 5'b01010));
        apply(1'b0, 1'b0);
        check("set64_after", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 1'b0, 5'b00000));

        // Asynchronous reset in ADV_P1 at games 3/2
        for (int g = 0; g < 5; g++) game(g[0]);
        repeat (3) apply(1'b1, 1'b0);
        repeat (3) apply(1'b0, 1'b1);
        apply(1'b1, 1'b0);
        check("adv_pre_reset", ex(3'd2, 2'd3, 2'd3, 3'd0, 3'd0, 3'd3, 3'd2, 3'd0, 3'd1, 1'b1, 5'b00000));
        @(negedge clk);
        p1_point = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_reset", 31'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 1'b1);
        check("after_reset_point", ex(3'd0, 2'd0, 2'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 5'b00000));

        // Games to 6-6, then tie-break or advantage-set play
        do_reset();
        for (int g = 0; g < 12; g++) game(g[0]);
        check("games66", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 1'b0, 5'b01000));
`ifdef TIEBREAK_EN
        apply(1'b0, 1'b0);
        check("tb_entry", ex(3'd4, 2'd0, 2'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 1'b0, 5'b00000));
        for (int k = 1; k <= 15; k++) begin
            apply(k[0], ~k[0]);
            check_bit($sformatf("tb_server_pt%0d", k), server, srv_exp[k-1]);
            if (k == 13)
                check("tb_7_6", ex(3'd4, 2'd0, 2'd0, 3'd7, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0, 1'b1, 5'b00000));
            if (k == 14)
                check("tb_norm", ex(3'd4, 2'd0, 2'd0, 3'd6, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0, 1'b1, 5'b00000));
            if (k == 15)
                check("tb_adv", ex(3'd4, 2'd0, 2'd0, 3'd7, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0, 1'b0, 5'b00000));
        end
        apply(1'b1, 1'b0);
        check("tb_win", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 1'b1, 5'b10100));
        apply(1'b0, 1'b0);
        check("tb_after", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 1'b1, 5'b00000));
`else
        game(1'b0);
        check("adv_76", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd7, 3'd6, 3'd0, 3'd0, 1'b1, 5'b10000));
        game(1'b1);
        check("adv_back66", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 1'b0, 5'b01000));
        game(1'b0);
        check("adv_76b", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd7, 3'd6, 3'd0, 3'd0, 1'b1, 5'b10000));
        game(1'b0);
        check("adv_set", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 1'b0, 5'b10100));
        apply(1'b0, 1'b0);
        check("adv_after", ex(3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 1'b0, 5'b00000));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
